// File: rtl/reg_view_pkg.sv
// Shared seven-segment helpers for the board display logic.
// Glyphs are active-low, bit order {g,f,e,d,c,b,a}.
// Contents: SEG_0..SEG_F glyph constants, SEG_BLANK, hex_to_seg().
package reg_view_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    case (nibble)
      4'h0: return SEG_0;
      4'h1: return SEG_1;
      4'h2: return SEG_2;
      4'h3: return SEG_3;
      4'h4: return SEG_4;
      4'h5: return SEG_5;
      4'h6: return SEG_6;
      4'h7: return SEG_7;
      4'h8: return SEG_8;
      4'h9: return SEG_9;
      4'hA: return SEG_A;
      4'hB: return SEG_B;
      4'hC: return SEG_C;
      4'hD: return SEG_D;
      4'hE: return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/reg_view_display_if.sv
// Signal bundle between the board top level and reg_view_display.
//   ch_data : packed channels, channel i at [i*DATA_W +: DATA_W]
//   Next    : raw push-button level (asynchronous)
//   Freeze  : hold displayed value, ignore Next
//   Sel     : current channel index
//   HEX     : DIGITS active-low data digits, digit 0 at [6:0]
//   HEX_SEL : active-low glyph of Sel
// master = board side driving inputs, slave = display block.
interface reg_view_display_if #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 8,
  parameter int DIGITS = 4
);
  logic [NUM_CH*DATA_W-1:0]   ch_data;
  logic                       Next;
  logic                       Freeze;
  logic [$clog2(NUM_CH)-1:0]  Sel;
  logic [DIGITS*7-1:0]        HEX;
  logic [6:0]                 HEX_SEL;

  modport master (output ch_data, Next, Freeze, input Sel, HEX, HEX_SEL);
  modport slave  (input ch_data, Next, Freeze, output Sel, HEX, HEX_SEL);
endinterface

// File: rtl/reg_view_display_debounce.sv
// button_debounce: 2-flop synchroniser, counter debouncer and 0->1 pulse.
//   Clock, Reset : clock, synchronous active-high reset
//   raw          : asynchronous button level
//   level        : debounced level
//   rise         : high in the cycle whose edge moves level 0->1
module button_debounce
  import reg_view_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          s1, s2, stable;
  logic [CW-1:0] cnt;
  logic          accept;

  // Disagreement has persisted for DEBOUNCE_CYC samples including this one.
  assign accept = (s2 != stable) && (cnt == CNT_LAST);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = stable;
  // Combinational so the channel step lands on the same edge as the level.
  assign rise  = accept & s2;
endmodule

// File: rtl/reg_view_display.sv
// reg_view_display: browsable register view on seven-segment displays.
//   Clock, Reset : clock, synchronous active-high reset
//   bus (slave)  : ch_data/Next/Freeze in, Sel/HEX/HEX_SEL out
// Build option REG_VIEW_BLANK_LEADING_ZEROS_EN: blank digits above the most
// significant non-zero nibble (digit 0 always shown).
module reg_view_display
  import reg_view_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int NUM_CH       = 8,
  parameter int DIGITS       = 4,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  reg_view_display_if.slave    bus
);
  localparam int SEL_W = $clog2(NUM_CH);
  localparam int HEX_W = DIGITS * 4;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_CH - 1);

  logic [SEL_W-1:0]           sel;
  logic [DATA_W-1:0]          shadow;
  logic [HEX_W-1:0]           padded;
  logic [DIGITS-1:0][6:0]     hex_d;
  logic                       level, rise;

  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn (
    .Clock (Clock),
    .Reset (Reset),
    .raw   (bus.Next),
    .level (level),
    .rise  (rise)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sel    <= '0;
      shadow <= '0;
    end else if (!bus.Freeze) begin
      // Shadow samples with the pre-step Sel, so a new channel shows one edge later.
      shadow <= bus.ch_data[int'(sel)*DATA_W +: DATA_W];
      if (rise && !level)
        sel <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
    end
  end

  assign padded = HEX_W'(shadow);

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
`ifdef REG_VIEW_BLANK_LEADING_ZEROS_EN
    if (i == 0) begin : g_lsd
      assign hex_d[i] = hex_to_seg(padded[i*4 +: 4]);
    end else begin : g_upper
      assign hex_d[i] = (padded[HEX_W-1:i*4] == '0) ? SEG_BLANK
                                                    : hex_to_seg(padded[i*4 +: 4]);
    end
`else
    assign hex_d[i] = hex_to_seg(padded[i*4 +: 4]);
`endif
  end

  assign bus.HEX     = hex_d;
  assign bus.Sel     = sel;
  assign bus.HEX_SEL = hex_to_seg(4'(sel));
endmodule

// File: tb/tb_reg_view_display.sv
module tb_reg_view_display;
  localparam int DC = 4;

  typedef struct {
    string       tag;
    logic [2:0]  sel;
    logic [27:0] hex;
    logic [6:0]  hsel;
  } exp_t;

  logic Clock, Reset;
  reg_view_display_if #(.DATA_W(16), .NUM_CH(5), .DIGITS(4)) bus ();

  reg_view_display #(.DATA_W(16), .NUM_CH(5), .DIGITS(4), .DEBOUNCE_CYC(DC)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  exp_t        sb[$];
  logic [15:0] chv [5];
  int          cur;
  int          total = 0;
  int          bad   = 0;

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [27:0] exp_hex(input logic [15:0] v);
    logic [27:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*7 +: 7] = seg(v[i*4 +: 4]);
`ifdef REG_VIEW_BLANK_LEADING_ZEROS_EN
      if (i > 0 && (v >> (i*4)) == 16'h0) r[i*7 +: 7] = 7'b1111111;
`endif
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [15:0] v);
    chv[i] = v;
    bus.ch_data[i*16 +: 16] = v;
  endtask

  // Push the expectation, then pop and compare against the live outputs.
  task automatic check(input string tag, input int s, input logic [15:0] v);
    exp_t e;
    e.tag  = tag;
    e.sel  = 3'(s);
    e.hex  = exp_hex(v);
    e.hsel = seg(4'(s));
    sb.push_back(e);
    e = sb.pop_front();
    total++;
    assert (bus.Sel === e.sel) else begin
      bad++;
      $error("FAIL %s Sel got=%0d want=%0d", e.tag, bus.Sel, e.sel);
    end
    total++;
    assert (bus.HEX === e.hex) else begin
      bad++;
      $error("FAIL %s HEX got=%h want=%h", e.tag, bus.HEX, e.hex);
    end
    total++;
    assert (bus.HEX_SEL === e.hsel) else begin
      bad++;
      $error("FAIL %s HEX_SEL got=%b want=%b", e.tag, bus.HEX_SEL, e.hsel);
    end
  endtask

  task automatic press(input int nxt);
    bus.Next = 1'b1;
    repeat (DC + 1) tick();
    check("press_hold", cur, chv[cur]);
    tick();
    check("press_step", nxt, chv[cur]);
    bus.Next = 1'b0;
    tick();
    check("press_show", nxt, chv[nxt]);
    repeat (DC + 6) tick();
    cur = nxt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    Reset      = 1'b1;
    bus.Next   = 1'b0;
    bus.Freeze = 1'b0;
    bus.ch_data = '0;
    set_ch(0, 16'h00A3);
    set_ch(1, 16'h1111);
    set_ch(2, 16'h2222);
    set_ch(3, 16'h3333);
    set_ch(4, 16'h4444);
    cur = 0;

    // reset
    repeat (2) tick();
    check("reset", 0, 16'h0000);
    Reset = 1'b0;
    tick();
    check("reset_release", 0, 16'h00A3);

    // short glitches rejected
    for (int k = 0; k < 2; k++) begin
      bus.Next = 1'b1;
      repeat (3) tick();
      bus.Next = 1'b0;
      repeat (6) tick();
      check("glitch3", 0, 16'h00A3);
    end

    // 6-cycle pulse steps at edge 6
    bus.Next = 1'b1;
    repeat (5) tick();
    check("pulse_e5", 0, 16'h00A3);
    tick();
    check("pulse_e6", 1, 16'h00A3);
    bus.Next = 1'b0;
    tick();
    check("pulse_e7", 1, 16'h1111);
    repeat (10) tick();
    cur = 1;

    // wrap-around across 5 channels
    set_ch(0, 16'h5555);
    press(2);
    press(3);
    press(4);
    press(0);

    // freeze
    set_ch(0, 16'h1234);
    tick();
    check("frz_pre", 0, 16'h1234);
    bus.Freeze = 1'b1;
    set_ch(0, 16'hBEEF);
    repeat (2) tick();
    check("frz_hold", 0, 16'h1234);
    bus.Next = 1'b1;
    repeat (DC + 4) tick();
    check("frz_press", 0, 16'h1234);
    bus.Next = 1'b0;
    repeat (DC + 6) tick();
    check("frz_release_btn", 0, 16'h1234);
    bus.Freeze = 1'b0;
    tick();
    check("frz_off", 0, 16'hBEEF);
    press(1);

    // reset in the middle of a held press
    bus.Next = 1'b1;
    repeat (3) tick();
    Reset = 1'b1;
    repeat (2) tick();
    check("rmd_reset", 0, 16'h0000);
    Reset = 1'b0;
    repeat (DC + 1) tick();
    check("rmd_hold", 0, 16'hBEEF);
    tick();
    check("rmd_step", 1, 16'hBEEF);
    repeat (10) tick();
    check("rmd_once", 1, 16'h1111);
    bus.Next = 1'b0;
    repeat (DC + 6) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
